// File: rtl/mul_share_ctrl.sv
// rtl/mul_share_ctrl.sv - two-requester round-robin sequencer around one shared external multiplier
module mul_share_ctrl #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [N-1:0]   req0_a,
   input  logic [N-1:0]   req0_b,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [N-1:0]   req1_a,
   input  logic [N-1:0]   req1_b,
   output logic [N-1:0]   mul_a,
   output logic [N-1:0]   mul_b,
   input  logic [2*N-1:0] mul_p,
   output logic           resp_valid,
   input  logic           resp_ready,
   output logic           resp_id,
   output logic [2*N-1:0] resp_product,
   output logic           busy,
   output logic [15:0]    op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [N-1:0]   op_a;
   logic [N-1:0]   op_b;
   logic           id_q;
   logic           last_grant;
   logic [2*N-1:0] product_q;
   logic [15:0]    count_q;
   logic           grant_any;
   logic           grant_id;

   // Under contention the requester not served last wins; a lone requester always wins.
   always_comb begin
      state_nxt  = state;
      grant_any  = 1'b0;
      grant_id   = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         IDLE: begin
            if (!rst && (req0_valid || req1_valid)) begin
               grant_any = 1'b1;
               if (req0_valid && req1_valid) begin
                  grant_id = ~last_grant;
               end else begin
                  grant_id = req1_valid;
               end
               state_nxt = CALC;
            end
         end
         CALC: state_nxt = RESP;
         RESP: begin
            if (resp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      req0_ready = grant_any && !grant_id;
      req1_ready = grant_any && grant_id;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         op_a       <= '0;
         op_b       <= '0;
         id_q       <= 1'b0;
         last_grant <= 1'b1;
         product_q  <= '0;
         count_q    <= '0;
      end else begin
         state <= state_nxt;
         if (grant_any) begin
            op_a       <= grant_id ? req1_a : req0_a;
            op_b       <= grant_id ? req1_b : req0_b;
            id_q       <= grant_id;
            last_grant <= grant_id;
         end
         // The multiplier sees only latched operands, so its product is settled in CALC.
         if (state == CALC) begin
            product_q <= mul_p;
         end
         if (state == RESP && resp_ready) begin
            count_q <= count_q + 16'd1;
         end
      end
   end

   assign mul_a        = op_a;
   assign mul_b        = op_b;
   assign resp_valid   = (state == RESP);
   assign resp_id      = id_q;
   assign resp_product = product_q;
   assign busy         = (state != IDLE);
   assign op_count     = count_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb/tb_mul_share_ctrl.sv - self-checking bench for mul_share_ctrl with a transaction-level reference model
module tb_mul_share_ctrl;

   localparam int N  = 8;
   localparam int W2 = 2 * N;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          req0_valid, req1_valid, resp_ready;
   logic [N-1:0]  req0_a, req0_b, req1_a, req1_b;
   logic          req0_ready, req1_ready, resp_valid, resp_id, busy;
   logic [N-1:0]  mul_a, mul_b;
   logic [W2-1:0] mul_p, resp_product;
   logic [15:0]   op_count;

   logic          w_req0_valid, w_req1_valid, w_resp_ready;
   logic [31:0]   w_req0_a, w_req0_b, w_req1_a, w_req1_b;
   logic          w_req0_ready, w_req1_ready, w_resp_valid, w_resp_id, w_busy;
   logic [31:0]   w_mul_a, w_mul_b;
   logic [63:0]   w_mul_p, w_resp_product;
   logic [15:0]   w_op_count;

   assign mul_p   = W2'(mul_a) * W2'(mul_b);
   assign w_mul_p = 64'(w_mul_a) * 64'(w_mul_b);

   mul_share_ctrl #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_product(resp_product), .busy(busy), .op_count(op_count)
   );

   mul_share_ctrl #(.N(32)) dut_w (
      .clk(clk), .rst(rst),
      .req0_valid(w_req0_valid), .req0_ready(w_req0_ready), .req0_a(w_req0_a), .req0_b(w_req0_b),
      .req1_valid(w_req1_valid), .req1_ready(w_req1_ready), .req1_a(w_req1_a), .req1_b(w_req1_b),
      .mul_a(w_mul_a), .mul_b(w_mul_b), .mul_p(w_mul_p),
      .resp_valid(w_resp_valid), .resp_ready(w_resp_ready), .resp_id(w_resp_id),
      .resp_product(w_resp_product), .busy(w_busy), .op_count(w_op_count)
   );

   int errors = 0;
   int checks = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change just after the rising edge; outputs are sampled on the falling edge.
   task automatic drv();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic do_reset();
      drv();
      rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      smp();
      check_eq("ready0_in_reset", 64'(req0_ready), 64'(0));
      check_eq("ready1_in_reset", 64'(req1_ready), 64'(0));
      drv();
      req0_valid = 1'b0; req1_valid = 1'b0;
      drv();
      rst = 1'b0;
   endtask

   task automatic random_phase(input int cycles);
      bit            outstanding = 1'b0;
      bit            last_m = 1'b1;
      bit            rv_exp;
      bit            exp_id = 1'b0;
      bit            pend [2];
      logic [N-1:0]  ra [2];
      logic [N-1:0]  rb [2];
      logic [W2-1:0] exp_prod = '0;
      int            acc_cyc = 0;
      int            count_m = 0;
      int            g;
      pend[0] = 1'b0; pend[1] = 1'b0;
      ra[0] = '0; ra[1] = '0; rb[0] = '0; rb[1] = '0;
      for (int c = 0; c < cycles; c++) begin
         drv();
         for (int i = 0; i < 2; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               ra[i] = N'($urandom);
               rb[i] = N'($urandom);
            end else if (pend[i] && $urandom_range(0, 9) == 0) begin
               pend[i] = 1'b0;
            end
         end
         req0_valid = pend[0]; req0_a = ra[0]; req0_b = rb[0];
         req1_valid = pend[1]; req1_a = ra[1]; req1_b = rb[1];
         resp_ready = ($urandom_range(0, 1) == 1);
         smp();
         if (outstanding)           g = -1;
         else if (pend[0] && pend[1]) g = last_m ? 0 : 1;
         else if (pend[0])          g = 0;
         else if (pend[1])          g = 1;
         else                       g = -1;
         check_eq("rnd_ready0", 64'(req0_ready), 64'(g == 0));
         check_eq("rnd_ready1", 64'(req1_ready), 64'(g == 1));
         rv_exp = outstanding && (c >= acc_cyc + 2);
         check_eq("rnd_resp_valid", 64'(resp_valid), 64'(rv_exp));
         if (rv_exp) begin
            check_eq("rnd_resp_id", 64'(resp_id), 64'(exp_id));
            check_eq("rnd_resp_product", 64'(resp_product), 64'(exp_prod));
         end
         check_eq("rnd_op_count", 64'(op_count), 64'(count_m[15:0]));
         if (rv_exp && resp_ready) begin
            outstanding = 1'b0;
            count_m++;
         end
         if (g >= 0) begin
            outstanding = 1'b1;
            acc_cyc     = c;
            exp_id      = g[0];
            exp_prod    = W2'(ra[g]) * W2'(rb[g]);
            last_m      = g[0];
            pend[g]     = 1'b0;
         end
      end
      drv();
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   initial begin
      bit grants [3];
      int ng;
      rst = 1'b1; resp_ready = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      w_req0_valid = 1'b0; w_req1_valid = 1'b0; w_resp_ready = 1'b0;
      w_req0_a = '0; w_req0_b = '0; w_req1_a = '0; w_req1_b = '0;
      grants[0] = 1'b0; grants[1] = 1'b0; grants[2] = 1'b0;

      // Reset state and single request A5*0F
      do_reset();
      smp();
      check_eq("rst_busy", 64'(busy), 64'(0));
      check_eq("rst_resp_valid", 64'(resp_valid), 64'(0));
      check_eq("rst_resp_product", 64'(resp_product), 64'(0));
      check_eq("rst_resp_id", 64'(resp_id), 64'(0));
      check_eq("rst_op_count", 64'(op_count), 64'(0));
      check_eq("rst_mul_a", 64'(mul_a), 64'(0));
      check_eq("rst_mul_b", 64'(mul_b), 64'(0));
      drv();
      req0_valid = 1'b1; req0_a = 8'hA5; req0_b = 8'h0F;
      smp();
      check_eq("a5_ready0", 64'(req0_ready), 64'(1));
      check_eq("a5_ready1", 64'(req1_ready), 64'(0));
      drv();
      req0_valid = 1'b0; req0_a = '0; req0_b = '0;
      smp();
      check_eq("a5_calc_resp_valid", 64'(resp_valid), 64'(0));
      check_eq("a5_calc_busy", 64'(busy), 64'(1));
      check_eq("a5_calc_mul_a", 64'(mul_a), 64'(8'hA5));
      check_eq("a5_calc_mul_b", 64'(mul_b), 64'(8'h0F));
      drv();
      resp_ready = 1'b1;
      smp();
      check_eq("a5_resp_valid", 64'(resp_valid), 64'(1));
      check_eq("a5_resp_id", 64'(resp_id), 64'(0));
      check_eq("a5_resp_product", 64'(resp_product), 64'(16'h09AB));
      drv();
      resp_ready = 1'b0;
      smp();
      check_eq("a5_op_count", 64'(op_count), 64'(1));
      check_eq("a5_idle_busy", 64'(busy), 64'(0));

      // Simultaneous requests after reset: req0 first, then req1
      do_reset();
      req0_valid = 1'b1; req0_a = 8'd3; req0_b = 8'd4;
      req1_valid = 1'b1; req1_a = 8'd5; req1_b = 8'd6;
      resp_ready = 1'b1;
      smp();
      check_eq("both_first_ready0", 64'(req0_ready), 64'(1));
      check_eq("both_first_ready1", 64'(req1_ready), 64'(0));
      drv();
      req0_valid = 1'b0;
      smp();
      check_eq("both_calc_ready1", 64'(req1_ready), 64'(0));
      drv();
      smp();
      check_eq("both_first_id", 64'(resp_id), 64'(0));
      check_eq("both_first_product", 64'(resp_product), 64'(12));
      drv();
      smp();
      check_eq("both_second_ready1", 64'(req1_ready), 64'(1));
      drv();
      req1_valid = 1'b0;
      smp();
      drv();
      smp();
      check_eq("both_second_valid", 64'(resp_valid), 64'(1));
      check_eq("both_second_id", 64'(resp_id), 64'(1));
      check_eq("both_second_product", 64'(resp_product), 64'(30));
      drv();
      smp();
      check_eq("both_op_count", 64'(op_count), 64'(2));

      // Fairness: req1 always valid, req0 joins after the first grant
      do_reset();
      req1_valid = 1'b1; req1_a = 8'd1; req1_b = 8'd1;
      resp_ready = 1'b1;
      ng = 0;
      for (int c = 0; c < 40 && ng < 3; c++) begin
         smp();
         if (req0_ready || req1_ready) begin
            grants[ng] = req1_ready;
            ng++;
         end
         drv();
         if (ng >= 1) begin
            req0_valid = 1'b1; req0_a = 8'd2; req0_b = 8'd2;
         end
      end
      check_eq("rr_grant_count", 64'(ng), 64'(3));
      check_eq("rr_grant0", 64'(grants[0]), 64'(1));
      check_eq("rr_grant1", 64'(grants[1]), 64'(0));
      check_eq("rr_grant2", 64'(grants[2]), 64'(1));
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Back-pressure: FF*FF held for 5 stalled cycles
      do_reset();
      req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'hFF;
      smp();
      drv();
      req0_valid = 1'b0;
      smp();
      for (int k = 0; k < 5; k++) begin
         drv();
         smp();
         check_eq("stall_resp_valid", 64'(resp_valid), 64'(1));
         check_eq("stall_product", 64'(resp_product), 64'(16'hFE01));
         check_eq("stall_op_count", 64'(op_count), 64'(0));
      end
      drv();
      resp_ready = 1'b1;
      smp();
      drv();
      resp_ready = 1'b0;
      smp();
      check_eq("stall_release_count", 64'(op_count), 64'(1));
      check_eq("stall_release_valid", 64'(resp_valid), 64'(0));
      drv();
      smp();
      check_eq("stall_single_increment", 64'(op_count), 64'(1));

      // Reset while in CALC discards the pending result
      do_reset();
      req0_valid = 1'b1; req0_a = 8'd3; req0_b = 8'd3;
      smp();
      check_eq("midrst_accept", 64'(req0_ready), 64'(1));
      drv();
      req0_valid = 1'b0; rst = 1'b1;
      smp();
      drv();
      rst = 1'b0;
      smp();
      check_eq("midrst_busy", 64'(busy), 64'(0));
      check_eq("midrst_resp_valid", 64'(resp_valid), 64'(0));
      check_eq("midrst_op_count", 64'(op_count), 64'(0));
      drv();
      req0_valid = 1'b1; req0_a = 8'd2; req0_b = 8'd1;
      smp();
      check_eq("midrst_next_ready0", 64'(req0_ready), 64'(1));
      drv();
      req0_valid = 1'b0; resp_ready = 1'b1;
      smp();
      drv();
      smp();
      check_eq("midrst_next_valid", 64'(resp_valid), 64'(1));
      check_eq("midrst_next_id", 64'(resp_id), 64'(0));
      check_eq("midrst_next_product", 64'(resp_product), 64'(2));
      drv();
      resp_ready = 1'b0;
      smp();
      check_eq("midrst_next_count", 64'(op_count), 64'(1));

      // 32-bit instance: full 64-bit product
      do_reset();
      w_req0_valid = 1'b1; w_req0_a = 32'h000ABCDE; w_req0_b = 32'h00000012;
      smp();
      check_eq("w_ready0", 64'(w_req0_ready), 64'(1));
      drv();
      w_req0_valid = 1'b0; w_resp_ready = 1'b1;
      smp();
      drv();
      smp();
      check_eq("w_resp_valid", 64'(w_resp_valid), 64'(1));
      check_eq("w_resp_product", w_resp_product, 64'h0000_0000_00C1_479C);
      drv();
      w_resp_ready = 1'b0;
      smp();
      check_eq("w_op_count", 64'(w_op_count), 64'(1));

      // Randomised traffic against the transaction model
      do_reset();
      random_phase(3000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete within the time limit");
      $fatal(1);
   end

endmodule

// File: doc/mul_share_ctrl.md
MUL_SHARE_CTRL -- requirements
Module: mul_share_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, operand width in bits (legal 2..32).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1 each, requester has an operand pair pending.
REQ-005 SHALL have ports req0_ready / req1_ready, output, 1 each, operand pair accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, N each, multiplicand and multiplier per requester.
REQ-007 SHALL have ports mul_a / mul_b, output, N each, operands driven to the shared external multiplier_cla instance.
REQ-008 SHALL have port mul_p, input, 2N, combinational product returned by the shared multiplier.
REQ-009 SHALL have port resp_valid, output, 1, result available.
REQ-010 SHALL have port resp_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port resp_id, output, 1, requester index owning the result.
REQ-012 SHALL have port resp_product, output, 2N, registered product.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-014 SHALL have port op_count, output, 16, number of completed responses.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, RESP; exactly one state active.
REQ-016 IDLE: if any reqX_valid, SHALL grant one requester, assert its reqX_ready combinationally that cycle, latch its operands and id, go to CALC; else stay IDLE.
REQ-017 reqX_ready SHALL be low in CALC and RESP and for the non-granted requester.
REQ-018 Arbitration SHALL be round-robin: both valid -> grant the requester not granted last; one valid -> grant it regardless of history.
REQ-019 last_grant SHALL update on the acceptance cycle only.
REQ-020 mul_a/mul_b SHALL be driven from latched operand registers only, never directly from request inputs.
REQ-021 CALC: SHALL capture mul_p into resp_product, go to RESP unconditionally (one cycle).
REQ-022 RESP: resp_valid SHALL be high; resp_product and resp_id SHALL stay stable until resp_ready sampled high.
REQ-023 RESP with resp_ready high: SHALL return to IDLE, increment op_count by 1 (wraps 0xFFFF -> 0x0000).
REQ-024 Latency: acceptance edge at cycle t -> resp_valid high from cycle t+2; minimum issue interval 3 cycles.
REQ-025 A requester dropping valid while not granted SHALL lose no state; no request SHALL be accepted twice.
REQ-026 Product SHALL be full 2N bits, unsigned, no truncation.

Reset
REQ-027 rst high at a clock edge SHALL force state IDLE, resp_valid 0, resp_product 0, resp_id 0, op_count 0, busy 0, latched operands 0, last_grant 1 (requester 0 wins first contention).
REQ-028 Reset mid-operation (CALC or RESP) SHALL discard the pending result without counting it.
REQ-029 reqX_ready SHALL be 0 in any cycle rst is high.

Verification
REQ-030 N=8, req0 A5*0F alone -> req0_ready 1 cycle, resp_valid at t+2, resp_id 0, resp_product 0x09AB (2475), op_count 1.
REQ-031 N=8, both valid same cycle, req0 03*04, req1 05*06, resp_ready held 1 -> first response id0 = 12, then id1 = 30; op_count 2.
REQ-032 N=8, req1 held valid continuously, req0 valid only after first grant -> grants alternate 1,0,1; no starvation.
REQ-033 N=8, FF*FF with resp_ready low 5 cycles -> resp_valid held, product 0xFE01 stable all 5 cycles, single op_count increment on release.
REQ-034 N=8, rst asserted in CALC -> next cycle IDLE, resp_valid 0, op_count unchanged at 0; subsequent 02*01 returns 2 with id0.
REQ-035 N=32, req0 000ABCDE*00000012 -> resp_product 0x0000000000C1479C (12666780).
